// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered BCD frame,
// one-hot digit drive with a blanking guard and a sanitized decoder input.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    lzb,
    output logic                    ready,
    output logic [3:0]              bcd_out,
    output logic                    dec_en,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start,
    output logic                    err
);
    localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic [4*NUM_DIGITS-1:0] r_pend_d, r_act_d, w_act_d_nxt;
    logic                    r_pend_z, r_pend_v, r_act_z, w_act_z_nxt;
    logic                    w_pend_v_nxt, w_take, w_accept, w_fs_nxt, w_lit;
    logic [NUM_DIGITS-1:0]   w_mask, w_sel_nxt;
    logic [3:0]              w_bcd_nxt;

    // A digit is dark if its code is illegal, or (with lzb) it and all higher digits are zero.
    function automatic logic [NUM_DIGITS-1:0] suppress_mask(input logic [4*NUM_DIGITS-1:0] d,
                                                            input logic z);
        logic [NUM_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (d[4*i +: 4] == 4'd0);
            m[i]     = (d[4*i +: 4] > 4'd9) | (z & all_zero & (i != 0));
        end
        return m;
    endfunction

    function automatic logic any_invalid(input logic [4*NUM_DIGITS-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bad = bad | (d[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    function automatic logic [3:0] sanitize(input logic [4*NUM_DIGITS-1:0] d,
                                            input logic [IW-1:0] idx);
        logic [3:0] c;
        c = d[4*int'(idx) +: 4];
        return (c > 4'd9) ? 4'd0 : c;
    endfunction

    assign w_accept = load & ~r_pend_v;

    // Scan sequencing and frame-boundary transfer of pending into active.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        w_fs_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_v) begin
                    w_take      = 1'b1;
                    w_fs_nxt    = 1'b1;
                    w_state_nxt = S_BLANK;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = S_SHOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_SHOW: begin
                if (r_cnt == DWELL_LAST) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt = '0;
                        w_fs_nxt  = 1'b1;
                        w_take    = r_pend_v;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_take) begin
            w_act_d_nxt  = r_pend_d;
            w_act_z_nxt  = r_pend_z;
            w_pend_v_nxt = 1'b0;
        end else begin
            w_act_d_nxt  = r_act_d;
            w_act_z_nxt  = r_act_z;
            w_pend_v_nxt = r_pend_v | w_accept;
        end
    end

    // Outputs are derived from next-state values so the registered outputs line up with the state.
    always_comb begin
        w_mask    = suppress_mask(w_act_d_nxt, w_act_z_nxt);
        w_lit     = (w_state_nxt == S_SHOW) & ~w_mask[w_idx_nxt];
        w_sel_nxt = '0;
        w_sel_nxt[w_idx_nxt] = w_lit;
        if (w_state_nxt == S_IDLE) begin
            w_bcd_nxt = 4'd0;
        end else begin
            w_bcd_nxt = sanitize(w_act_d_nxt, w_idx_nxt);
        end
    end

    // State, frame buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_pend_d    <= '0;
            r_pend_z    <= 1'b0;
            r_pend_v    <= 1'b0;
            r_act_d     <= '0;
            r_act_z     <= 1'b0;
            ready       <= 1'b1;
            bcd_out     <= 4'd0;
            dec_en      <= 1'b0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_act_d  <= w_act_d_nxt;
            r_act_z  <= w_act_z_nxt;
            if (w_accept) begin
                r_pend_d <= digits_in;
                r_pend_z <= lzb;
            end
            ready       <= ~w_pend_v_nxt;
            bcd_out     <= w_bcd_nxt;
            dec_en      <= w_lit;
            digit_sel   <= w_sel_nxt;
            frame_start <= w_fs_nxt;
            err         <= any_invalid(w_act_d_nxt);
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for a multi-digit 7-segment display that shares one BCD-to-segment decoder bank across all digits. It holds a frame of BCD digits and presents one digit at a time to the shared decoder. It drives a one-hot digit select with a blanking guard between digits to prevent ghosting. It also enforces legal BCD (0–9) at the decoder input, since the decoder treats codes 10–15 as don't-care.

## Interface
- NUM_DIGITS, 4, number of display digits (2..8)
- DWELL, 1000, cycles each digit is lit per frame (≥1)
- BLANK_CYC, 2, guard cycles with all digits off before each digit (≥1)
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- load  input  1  request to accept new frame data
- digits_in  input  4*NUM_DIGITS  BCD digits; digit i = bits [4i+3:4i], digit 0 least significant
- lzb  input  1  leading-zero blanking enable, sampled with load
- ready  output  1  high when load will be accepted this cycle
- bcd_out  output  4  digit code to shared decoder, always 0–9
- dec_en  output  1  high while a digit is lit
- digit_sel  output  NUM_DIGITS  one-hot digit drive, all-zero when blanked
- frame_start  output  1  one-cycle pulse in first BLANK cycle of digit 0
- err  output  1  high while the active frame contains any code ≥10

Clock and reset are fixed as above: one clock `clk`, and a synchronous, active-high `reset`.

## Operation
- Registers:
  - pending frame: digits + lzb + valid flag
  - active frame: digits + lzb
  - digit index idx (0..NUM_DIGITS-1)
  - cycle counter cnt
- Handshake:
  - ready = !pending_valid.
  - load && ready captures digits_in and lzb into pending and sets pending_valid.
  - load while ready=0 is ignored; it does not overwrite pending.
- FSM states:
  - IDLE: no active frame; outputs off.
    - Leaves when pending_valid: pending copies to active, pending_valid clears, next state BLANK with idx=0.
  - BLANK: BLANK_CYC cycles; digit_sel=0, dec_en=0, bcd_out = sanitized code of active digit idx.
    - Then goes to SHOW.
  - SHOW: DWELL cycles; digit_sel[idx]=1 unless that digit is suppressed; dec_en=1 iff not suppressed.
    - At the end, if idx<NUM_DIGITS-1: idx++ and go to BLANK.
    - Otherwise it is a frame boundary: if pending_valid, copy pending to active and clear pending_valid. Then idx=0 and go to BLANK. The FSM never returns to IDLE except by reset.
- Sanitize and suppress rule, evaluated on the active frame:
  - Digit code ≥10: bcd_out=0 and the digit is suppressed.
  - lzb=1: digit i (i≥1) is suppressed if it and every digit above it are 0.
  - Digit 0 is never suppressed by lzb.
- err = OR over active digits of (code ≥10); updates on each active-frame transfer.
- Frame length = NUM_DIGITS*(BLANK_CYC+DWELL) cycles. A transfer never cuts a frame short.

## Timing
- All outputs are registered. Reset values: ready=1, bcd_out=0, dec_en=0, digit_sel=0, frame_start=0, err=0, state IDLE, pending_valid=0.
- Reset asserted mid-operation: in the next cycle every output takes its reset value and pending data is discarded.
- Accept to ready low: ready falls the cycle after the accepting edge.
- From IDLE:
  - The cycle after accept: transfer occurs, ready returns high, state BLANK.
  - frame_start pulses in that first BLANK cycle.
  - digit_sel goes non-zero BLANK_CYC cycles later.
- From scanning: ready returns high the cycle after the frame-boundary transfer. Worst-case wait is one full frame.
- bcd_out changes only on entry to BLANK, so it is stable ≥BLANK_CYC cycles before digit_sel asserts.
- digit_sel is never non-zero in two consecutive cycles for different digits; at least BLANK_CYC zero cycles separate digits.
- load asserted in the same cycle as a frame-boundary transfer: pending is full that cycle (ready=0), so the load is ignored.
- idx wraps NUM_DIGITS-1 → 0. cnt wraps per state with no dead cycles.

## Test plan
Bench parameters: NUM_DIGITS=4, DWELL=4, BLANK_CYC=1.

- Reset, then idle 20 cycles -> digit_sel=0, dec_en=0, bcd_out=0, ready=1, err=0 throughout.
- Load digits {3,2,1,0} (digit0=0), lzb=0 -> frame_start one cycle after accept; 20-cycle frame; per digit, 1 blank cycle then 4 lit cycles; digit_sel 0001,0010,0100,1000 with bcd_out 0,1,2,3; repeats every 20 cycles.
- Load {0,0,5,0} with lzb=1 -> digits 3 and 2 suppressed (digit_sel=0, dec_en=0 in their slots); digits 1 and 0 shown as 5 and 0. Load {0,0,0,0} with lzb=1 -> only digit 0 lit, showing 0.
- Load with digit 2 = 4'hC -> err=1; in digit 2's slot bcd_out=0 and digit_sel=0. Next load of all-valid data -> err=0 after that frame's transfer.
- Mid-frame, load A (accepted, ready=0), then assert load with B for 5 cycles -> B ignored; A becomes active at the frame boundary; ready=1 the cycle after.
- Reset asserted during a SHOW of digit 2 with a pending load -> all outputs at reset values the next cycle; after reset, the FSM stays in IDLE (pending was discarded).
